// File: rtl/countdown_timer_ctrl_if.sv
// Command/status bundle between the game FSM (master) and the countdown timer (slave).
interface countdown_timer_ctrl_if;
   logic        start;
   logic        pause;
   logic        clear;
   logic [15:0] preset;
   logic [15:0] digits;
   logic        running;
   logic        tick;
   logic        expired;

   modport master (
      output start, pause, clear, preset,
      input  digits, running, tick, expired
   );

   modport slave (
      input  start, pause, clear, preset,
      output digits, running, tick, expired
   );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// 4-digit BCD countdown timer with prescaler and start/pause/clear sequencing.
// Optional AUTO_RELOAD_EN: on expiry, reload the clamped preset and keep running.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | cleared, digits 0000, waiting for start
//   S_RUN    | prescaler counting, digits decrement per tick
//   S_PAUSED | prescaler and digits held, start resumes
//   S_DONE   | count reached 0000, waiting for start/clear
module countdown_timer_ctrl #(
   parameter int PRESCALE_WIDTH = 27,
   parameter int PRESCALE_MAX   = 49999999
) (
   input  logic                    clk,
   input  logic                    reset,
   countdown_timer_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   localparam logic [PRESCALE_WIDTH-1:0] PRE_TC = PRESCALE_WIDTH'(PRESCALE_MAX);

   state_t                    state_q, state_nxt;
   logic [PRESCALE_WIDTH-1:0] pre_q, pre_nxt;
   logic [15:0]               digits_q, digits_nxt;
   logic                      running_q, running_nxt;
   logic                      tick_q, tick_nxt;
   logic                      expired_q, expired_nxt;
   logic [15:0]               preset_clamped;
   logic [15:0]               digits_dec;

   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++)
         if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
      return r;
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (v[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign preset_clamped = clamp_bcd(bus.preset);
   assign digits_dec     = bcd_dec(digits_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         digits_q  <= 16'h0000;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         pre_q     <= pre_nxt;
         digits_q  <= digits_nxt;
         running_q <= running_nxt;
         tick_q    <= tick_nxt;
         expired_q <= expired_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      pre_nxt     = pre_q;
      digits_nxt  = digits_q;
      tick_nxt    = 1'b0;
      expired_nxt = 1'b0;

      if (bus.clear) begin
         state_nxt  = S_IDLE;
         pre_nxt    = '0;
         digits_nxt = 16'h0000;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               pre_nxt = '0;
               if (bus.start) begin
                  digits_nxt = preset_clamped;
                  if (preset_clamped == 16'h0000) begin
                     state_nxt   = S_DONE;
                     expired_nxt = 1'b1;
                  end else begin
                     state_nxt = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (pre_q == PRE_TC) begin
                  // Terminal cycle decrements even when pause arrives on it.
                  pre_nxt    = '0;
                  digits_nxt = digits_dec;
                  tick_nxt   = 1'b1;
                  if (digits_dec == 16'h0000) begin
                     expired_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                     if (preset_clamped != 16'h0000) begin
                        digits_nxt = preset_clamped;
                        state_nxt  = S_RUN;
                     end else begin
                        state_nxt = S_DONE;
                     end
`else
                     state_nxt = S_DONE;
`endif
                  end else if (bus.pause) begin
                     state_nxt = S_PAUSED;
                  end
               end else if (bus.pause) begin
                  state_nxt = S_PAUSED;
               end else begin
                  pre_nxt = pre_q + PRESCALE_WIDTH'(1);
               end
            end
            S_PAUSED: begin
               if (bus.start) state_nxt = S_RUN;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end

      running_nxt = (state_nxt == S_RUN);
   end

   assign bus.digits  = digits_q;
   assign bus.running = running_q;
   assign bus.tick    = tick_q;
   assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with a 4-cycle tick period.
module tb_countdown_timer_ctrl;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   countdown_timer_ctrl_if bus ();

   countdown_timer_ctrl #(
      .PRESCALE_WIDTH (27),
      .PRESCALE_MAX   (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Three quiet cycles then the tick cycle with the expected registered outputs.
   task automatic run_tick(input logic [15:0] d, input logic x, input logic r);
      repeat (3) step();
      chk("tick_quiet", 32'(bus.tick), 32'd0);
      step();
      chk("tick_pulse", 32'(bus.tick), 32'd1);
      chk("tick_digits", 32'(bus.digits), 32'(d));
      chk("tick_expired", 32'(bus.expired), 32'(x));
      chk("tick_running", 32'(bus.running), 32'(r));
   endtask

   initial begin
      logic [15:0] e;
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.pause  = 1'b0;
      bus.clear  = 1'b0;
      bus.preset = 16'h0000;

      step();
      step();
      chk("rst_digits", 32'(bus.digits), 32'h0000);
      chk("rst_running", 32'(bus.running), 32'd0);
      chk("rst_tick", 32'(bus.tick), 32'd0);
      chk("rst_expired", 32'(bus.expired), 32'd0);
      reset = 1'b0;
      step();

      // Basic countdown from 0012.
      bus.preset = 16'h0012;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk("load_running", 32'(bus.running), 32'd1);
      chk("load_digits", 32'(bus.digits), 32'h0012);
      chk("load_tick", 32'(bus.tick), 32'd0);
      for (int n = 11; n >= 1; n--) begin
         e = {8'h00, 4'(n / 10), 4'(n % 10)};
         run_tick(e, 1'b0, 1'b1);
      end
`ifdef AUTO_RELOAD_EN
      run_tick(16'h0012, 1'b1, 1'b1);
`else
      run_tick(16'h0000, 1'b1, 1'b0);
      step();
      chk("done_hold_digits", 32'(bus.digits), 32'h0000);
      chk("done_expired_off", 32'(bus.expired), 32'd0);
      chk("done_tick_off", 32'(bus.tick), 32'd0);
`endif
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      chk("clear_digits", 32'(bus.digits), 32'h0000);
      chk("clear_running", 32'(bus.running), 32'd0);

      // Borrow across three digits.
      bus.preset = 16'h1000;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      run_tick(16'h0999, 1'b0, 1'b1);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;

      // Clamp on load, start ignored in RUN, then pause/resume timing.
      bus.preset = 16'h00AF;
      bus.start  = 1'b1;
      step();
      chk("clamp_digits", 32'(bus.digits), 32'h0099);
      bus.preset = 16'h0050;
      step();
      bus.start = 1'b0;
      chk("run_start_ignored", 32'(bus.digits), 32'h0099);
      chk("run_start_running", 32'(bus.running), 32'd1);
      step();
      bus.pause = 1'b1;
      step();
      chk("pause_running", 32'(bus.running), 32'd0);
      for (int i = 0; i < 9; i++) begin
         step();
         chk("pause_no_tick", 32'(bus.tick), 32'd0);
      end
      chk("pause_digits", 32'(bus.digits), 32'h0099);
      bus.pause = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("resume_running", 32'(bus.running), 32'd1);
      step();
      chk("resume_tick_early", 32'(bus.tick), 32'd0);
      step();
      chk("resume_tick", 32'(bus.tick), 32'd1);
      chk("resume_digits", 32'(bus.digits), 32'h0098);

      // Clear wins over start in RUN.
      bus.clear = 1'b1;
      bus.start = 1'b1;
      step();
      bus.clear = 1'b0;
      bus.start = 1'b0;
      chk("clr_start_running", 32'(bus.running), 32'd0);
      chk("clr_start_digits", 32'(bus.digits), 32'h0000);

      // Zero preset goes straight to DONE.
      bus.preset = 16'h0000;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk("zero_expired", 32'(bus.expired), 32'd1);
      chk("zero_running", 32'(bus.running), 32'd0);
      chk("zero_tick", 32'(bus.tick), 32'd0);
      step();
      chk("zero_expired_off", 32'(bus.expired), 32'd0);

      // Reset mid-run.
      bus.preset = 16'h0005;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_digits", 32'(bus.digits), 32'h0000);
      chk("midrst_running", 32'(bus.running), 32'd0);

`ifndef AUTO_RELOAD_EN
      // Pause on the terminal cycle reaching 0000 ends in DONE.
      bus.preset = 16'h0001;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("pause_tc_tick", 32'(bus.tick), 32'd1);
      chk("pause_tc_expired", 32'(bus.expired), 32'd1);
      chk("pause_tc_digits", 32'(bus.digits), 32'h0000);
      chk("pause_tc_running", 32'(bus.running), 32'd0);
      bus.preset = 16'h0003;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_from_done", 32'(bus.digits), 32'h0003);
`else
      // Auto reload: 0002 -> 0001 -> 0002 with expiry at the reload tick.
      bus.preset = 16'h0002;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      run_tick(16'h0001, 1'b0, 1'b1);
      run_tick(16'h0002, 1'b1, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
